// File: rtl/srt_pkg.sv
// rtl/srt_pkg.sv - shared state encoding and default sizes for the sort result checker
package srt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SCAN = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 1024;

endpackage

// File: rtl/srt_order_cmp.sv
// rtl/srt_order_cmp.sv - flags an adjacent pair (a = earlier, b = later) that breaks the requested order
module srt_order_cmp
    import srt_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter bit SIGNED_C = 1'b1
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              dir,
    output logic              viol
);

    logic a_gt_b;
    logic a_lt_b;

    always_comb begin
        if (SIGNED_C) begin
            a_gt_b = $signed(a) > $signed(b);
            a_lt_b = $signed(a) < $signed(b);
        end else begin
            a_gt_b = a > b;
            a_lt_b = a < b;
        end
        // equal elements satisfy either direction
        viol = dir ? a_gt_b : a_lt_b;
    end

endmodule

// File: rtl/srt_result_checker.sv
// rtl/srt_result_checker.sv - one-pass order verifier over the sort RAM; SRT_CHK_SUM_EN adds an element sum output
module srt_result_checker
    import srt_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter bit SIGNED_C = 1'b1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              up,
    output logic [ADDR_W-1:0] mem_a,
    input  logic [DATA_W-1:0] mem_spo,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] err_index,
`ifdef SRT_CHK_SUM_EN
    output logic [DATA_W-1:0] sum,
`endif
    output logic [ADDR_W-1:0] err_count
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_t            state;
    state_t            state_n;
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] prev;
    logic              dir;
    logic              first;
    logic              viol;

    srt_order_cmp #(
        .DATA_W   (DATA_W),
        .SIGNED_C (SIGNED_C)
    ) u_cmp (
        .a    (prev),
        .b    (mem_spo),
        .dir  (dir),
        .viol (viol)
    );

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE, ST_DONE: if (start) state_n = ST_LOAD;
            ST_LOAD:          state_n = ST_SCAN;
            ST_SCAN:          if (idx == LAST_IDX) state_n = ST_DONE;
            default:          state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            idx       <= '0;
            prev      <= '0;
            dir       <= 1'b0;
            first     <= 1'b0;
            err_count <= '0;
            err_index <= '0;
`ifdef SRT_CHK_SUM_EN
            sum       <= '0;
`endif
        end else begin
            state <= state_n;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        dir       <= up;
                        first     <= 1'b1;
                        err_count <= '0;
                        err_index <= '0;
`ifdef SRT_CHK_SUM_EN
                        sum       <= '0;
`endif
                    end
                end
                ST_LOAD: begin
                    prev <= mem_spo;
                    idx  <= ADDR_W'(1);
`ifdef SRT_CHK_SUM_EN
                    sum  <= sum + mem_spo;
`endif
                end
                ST_SCAN: begin
                    prev <= mem_spo;
`ifdef SRT_CHK_SUM_EN
                    sum  <= sum + mem_spo;
`endif
                    if (viol) begin
                        err_count <= err_count + 1'b1;
                        if (first) begin
                            err_index <= idx;
                            first     <= 1'b0;
                        end
                    end
                    // idx parks on the last index so it never wraps
                    if (idx != LAST_IDX) idx <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign mem_a = (state == ST_SCAN) ? idx : '0;
    assign busy  = (state == ST_LOAD) || (state == ST_SCAN);
    assign done  = (state == ST_DONE);
    assign pass  = (state == ST_DONE) && (err_count == '0);

endmodule

// File: tb/tb_srt_result_checker.sv
// tb/tb_srt_result_checker.sv - directed vector bench for srt_result_checker (signed and unsigned builds side by side)
module tb_srt_result_checker;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int DEPTH = 1024;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic          up = 1'b0;
    logic [DW-1:0] mem [DEPTH];

    logic [AW-1:0] mem_a_s, mem_a_u, err_index_s, err_index_u, err_count_s, err_count_u;
    logic [DW-1:0] mem_spo_s, mem_spo_u;
    logic          busy_s, busy_u, done_s, done_u, pass_s, pass_u;
`ifdef SRT_CHK_SUM_EN
    logic [DW-1:0] sum_s, sum_u;
`endif

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign mem_spo_s = mem[mem_a_s];
    assign mem_spo_u = mem[mem_a_u];

    srt_result_checker #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .SIGNED_C(1'b1)) dut_s (
        .clk(clk), .rstn(rstn), .start(start), .up(up), .mem_a(mem_a_s), .mem_spo(mem_spo_s),
        .busy(busy_s), .done(done_s), .pass(pass_s), .err_index(err_index_s),
`ifdef SRT_CHK_SUM_EN
        .sum(sum_s),
`endif
        .err_count(err_count_s)
    );

    srt_result_checker #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .SIGNED_C(1'b0)) dut_u (
        .clk(clk), .rstn(rstn), .start(start), .up(up), .mem_a(mem_a_u), .mem_spo(mem_spo_u),
        .busy(busy_u), .done(done_u), .pass(pass_u), .err_index(err_index_u),
`ifdef SRT_CHK_SUM_EN
        .sum(sum_u),
`endif
        .err_count(err_count_u)
    );

    typedef struct {
        int pat;
        bit up;
        bit e_pass_s; int e_cnt_s; int e_idx_s;
        bit e_pass_u; int e_cnt_u; int e_idx_u;
    } vec_t;

    vec_t vt [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // 0 ascending, 1 ascending with 500/501 swapped, 2 -1 then 0..1022,
    // 3 all 5, 4 descending, 5 ascending with last element 0
    task automatic fill(input int p);
        for (int i = 0; i < DEPTH; i++) begin
            case (p)
                2:       mem[i] = (i == 0) ? 32'hFFFF_FFFF : 32'(i - 1);
                3:       mem[i] = 32'h5;
                4:       mem[i] = 32'(DEPTH - 1 - i);
                5:       mem[i] = (i == DEPTH - 1) ? 32'h0 : 32'(i);
                default: mem[i] = 32'(i);
            endcase
        end
        if (p == 1) begin
            mem[500] = 32'd501;
            mem[501] = 32'd500;
        end
    endtask

    task automatic start_scan(input bit dir_up);
        @(negedge clk);
        start = 1'b1;
        up    = dir_up;
        @(negedge clk);
        start = 1'b0;
    endtask

    // cycles counts clock edges from the one that accepts start until done is seen
    task automatic wait_done(input int already, output int cycles);
        cycles = already;
        while (!(done_s && done_u) && cycles < 3 * DEPTH) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    initial begin
        int cyc;
        logic [DW-1:0] exp_sum;

        vt[0] = '{0, 1'b1, 1'b1, 0, 0,       1'b1, 0, 0};
        vt[1] = '{0, 1'b0, 1'b0, 1023, 1,    1'b0, 1023, 1};
        vt[2] = '{1, 1'b1, 1'b0, 1, 501,     1'b0, 1, 501};
        vt[3] = '{2, 1'b1, 1'b1, 0, 0,       1'b0, 1, 1};
        vt[4] = '{2, 1'b0, 1'b0, 1023, 1,    1'b0, 1022, 2};
        vt[5] = '{3, 1'b1, 1'b1, 0, 0,       1'b1, 0, 0};
        vt[6] = '{3, 1'b0, 1'b1, 0, 0,       1'b1, 0, 0};
        vt[7] = '{4, 1'b0, 1'b1, 0, 0,       1'b1, 0, 0};
        vt[8] = '{4, 1'b1, 1'b0, 1023, 1,    1'b0, 1023, 1};
        vt[9] = '{5, 1'b1, 1'b0, 1, 1023,    1'b0, 1, 1023};

        fill(0);
        repeat (3) @(negedge clk);
        check("rst_busy", busy_s, 0);
        check("rst_done", done_s, 0);
        check("rst_pass", pass_s, 0);
        check("rst_mem_a", mem_a_s, 0);
        check("rst_err_index", err_index_s, 0);
        check("rst_err_count", err_count_s, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("idle_busy", busy_s, 0);

        for (int v = 0; v < 10; v++) begin
            fill(vt[v].pat);
            start_scan(vt[v].up);
            check($sformatf("v%0d_load_busy", v), busy_s, 1);
            check($sformatf("v%0d_load_mem_a", v), mem_a_s, 0);
            wait_done(1, cyc);
            check($sformatf("v%0d_latency", v), cyc, DEPTH + 1);
            check($sformatf("v%0d_busy_done", v), busy_s, 0);
            check($sformatf("v%0d_pass_s", v), pass_s, vt[v].e_pass_s);
            check($sformatf("v%0d_cnt_s", v), err_count_s, vt[v].e_cnt_s);
            check($sformatf("v%0d_idx_s", v), err_index_s, vt[v].e_idx_s);
            check($sformatf("v%0d_pass_u", v), pass_u, vt[v].e_pass_u);
            check($sformatf("v%0d_cnt_u", v), err_count_u, vt[v].e_cnt_u);
            check($sformatf("v%0d_idx_u", v), err_index_u, vt[v].e_idx_u);
`ifdef SRT_CHK_SUM_EN
            exp_sum = '0;
            for (int i = 0; i < DEPTH; i++) exp_sum = exp_sum + mem[i];
            check($sformatf("v%0d_sum", v), sum_s, exp_sum);
            if (v == 0) check("v0_sum_const", sum_s, 32'h0007_FE00);
`endif
            repeat (2) @(negedge clk);
            check($sformatf("v%0d_done_held", v), done_s, 1);
        end

        // start while busy must not disturb the scan or its direction
        fill(0);
        start_scan(1'b1);
        repeat (20) @(negedge clk);
        start = 1'b1;
        up    = 1'b0;
        @(negedge clk);
        start = 1'b0;
        wait_done(22, cyc);
        check("busy_start_latency", cyc, DEPTH + 1);
        check("busy_start_pass", pass_s, 1);
        check("busy_start_cnt", err_count_s, 0);

        // start from DONE after a failing scan clears results and restarts
        start_scan(1'b0);
        wait_done(1, cyc);
        check("redo_first_cnt", err_count_s, 1023);
        start_scan(1'b1);
        check("redo_done_drop", done_s, 0);
        check("redo_busy", busy_s, 1);
        check("redo_cnt_clear", err_count_s, 0);
        check("redo_pass_clear", pass_s, 0);
        wait_done(1, cyc);
        check("redo_latency", cyc, DEPTH + 1);
        check("redo_pass", pass_s, 1);

        // asynchronous reset in the middle of a failing scan
        start_scan(1'b0);
        cyc = 0;
        while (mem_a_s != 10'd300 && cyc < 2 * DEPTH) begin
            @(negedge clk);
            cyc++;
        end
        check("mid_reach_300", mem_a_s, 300);
        check("mid_cnt_before", err_count_s, 299);
        rstn = 1'b0;
        #1;
        check("mid_busy", busy_s, 0);
        check("mid_done", done_s, 0);
        check("mid_mem_a", mem_a_s, 0);
        check("mid_err_count", err_count_s, 0);
        check("mid_err_index", err_index_s, 0);
`ifdef SRT_CHK_SUM_EN
        check("mid_sum", sum_s, 0);
`endif
        repeat (2) @(negedge clk);
        check("mid_idle_busy", busy_s, 0);
        rstn = 1'b1;
        start_scan(1'b1);
        wait_done(1, cyc);
        check("after_rst_latency", cyc, DEPTH + 1);
        check("after_rst_pass", pass_s, 1);
        check("after_rst_cnt", err_count_s, 0);
`ifdef SRT_CHK_SUM_EN
        check("after_rst_sum", sum_s, 32'h0007_FE00);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
